alu_mul_seq: RTL and testbench

ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

---
 rtl/alu_mul_seq.sv | 116 +++++++++++
 tb/tb_alu_mul_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// Sequential shift-and-add multiplier that borrows a shared external ALU for
// every add and shift; one ALU operation per cycle, three cycles per iteration.
module alu_mul_seq #(
  parameter int         WIDTH  = 16,
  parameter logic [1:0] OP_ADD = 2'd0,
  parameter logic [1:0] OP_SHL = 2'd1,
  parameter logic [1:0] OP_SHR = 2'd2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [1:0]       alu_fs,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_c
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    SHL,
    SHR,
    DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               last_iter;

  // Stop once the shifted multiplier runs out of set bits, or after WIDTH passes.
  assign last_iter = (alu_c == '0) || (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    alu_fs    = OP_ADD;
    alu_a     = '0;
    alu_b     = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ADD;
      end
      ADD: begin
        busy      = 1'b1;
        alu_a     = acc;
        alu_b     = mcand;
        state_nxt = SHL;
      end
      SHL: begin
        busy      = 1'b1;
        alu_fs    = OP_SHL;
        alu_a     = mcand;
        state_nxt = SHR;
      end
      SHR: begin
        busy      = 1'b1;
        alu_fs    = OP_SHR;
        alu_a     = mplier;
        state_nxt = last_iter ? DONE : ADD;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? ADD : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        ADD: begin
          if (mplier[0]) acc <= alu_c;
        end
        SHL: begin
          mcand <= alu_c;
        end
        SHR: begin
          mplier <= alu_c;
          cnt    <= cnt + CNT_W'(1);
          if (last_iter) product <= acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: directed corner cases plus randomized
// operands compared against an arithmetic product/latency model.
module tb_alu_mul_seq;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] product;
  logic [1:0]   alu_fs;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_c;

  int total = 0;
  int bad   = 0;

  alu_mul_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .alu_fs  (alu_fs),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_c   (alu_c)
  );

  // The shared external ALU.
  always_comb begin
    case (alu_fs)
      2'd0:    alu_c = alu_a + alu_b;
      2'd1:    alu_c = alu_a << 1;
      2'd2:    alu_c = alu_a >> 1;
      default: alu_c = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_lat(input logic [W-1:0] bv);
    int n = 1;
    for (int i = 0; i < W; i++) if (bv[i]) n = i + 1;
    return 1 + 3 * n;
  endfunction

  function automatic logic [W-1:0] ref_prod(input logic [W-1:0] av, input logic [W-1:0] bv);
    longint unsigned p = longint'(av) * longint'(bv);
    return p[W-1:0];
  endfunction

  // Called right after start was raised at a negedge; counts cycles after the
  // accepting edge until done, checking busy and the ADD/SHL/SHR order.
  task automatic wait_done(input string tag, input logic [W-1:0] bv, input logic [W-1:0] pv,
                           input bit hold, input int inj_at);
    int  m    = 0;
    bit  seen = 0;
    while (!seen && m < 200) begin
      @(negedge clk);
      m++;
      if (m == 1 && !hold) start = 1'b0;
      if (inj_at > 0 && m == inj_at) begin
        start = 1'b1; a = 16'd1; b = 16'd1;
      end
      if (inj_at > 0 && m == inj_at + 1) start = 1'b0;
      if (done) seen = 1;
      else begin
        check({tag, ".busy"}, busy, 1);
        check({tag, ".fs"}, alu_fs, (m - 1) % 3);
      end
    end
    check({tag, ".lat"}, m, ref_lat(bv));
    check({tag, ".busy_at_done"}, busy, 0);
    check({tag, ".prod"}, product, pv);
  endtask

  task automatic check_idle(input string tag, input logic [W-1:0] pv);
    @(negedge clk);
    check({tag, ".idle_done"}, done, 0);
    check({tag, ".idle_busy"}, busy, 0);
    check({tag, ".idle_alu"}, {alu_fs, alu_a, alu_b}, 0);
    check({tag, ".idle_prod"}, product, pv);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [31:0]  mask;
    bit           seen;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #3;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.prod", product, 0);
    check("rst.alu", {alu_fs, alu_a, alu_b}, 0);
    repeat (3) @(negedge clk);

    // First start right at reset release: 3*5.
    rst_n = 1'b1; start = 1'b1; a = 16'd3; b = 16'd5;
    wait_done("m3x5", 16'd5, 16'd15, 0, 0);
    check_idle("m3x5", 16'd15);

    @(negedge clk); start = 1'b1; a = 16'h1234; b = 16'd0;
    wait_done("bzero", 16'd0, 16'd0, 0, 0);
    check_idle("bzero", 16'd0);

    @(negedge clk); start = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
    wait_done("ffff", 16'hFFFF, 16'h0001, 0, 0);
    check_idle("ffff", 16'h0001);

    @(negedge clk); start = 1'b1; a = 16'd7; b = 16'h8000;
    wait_done("msb_ign", 16'h8000, 16'h8000, 0, 20);
    check_idle("msb_ign", 16'h8000);

    // Back-to-back with start held through DONE.
    @(negedge clk); start = 1'b1; a = 16'd2; b = 16'd3;
    wait_done("b2b1", 16'd3, 16'd6, 1, 0);
    a = 16'd4; b = 16'd4;
    wait_done("b2b2", 16'd4, 16'd16, 0, 0);
    check_idle("b2b2", 16'd16);

    // Reset during SHL abandons the operation.
    @(negedge clk); start = 1'b1; a = 16'd3; b = 16'd5;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("rstmid.fs_shl", alu_fs, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid.busy", busy, 0);
    check("rstmid.done", done, 0);
    check("rstmid.prod", product, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    check("rstmid.quiet", seen, 0);
    check("rstmid.prod_hold", product, 0);
    @(negedge clk); start = 1'b1; a = 16'd3; b = 16'd5;
    wait_done("rstmid.redo", 16'd5, 16'd15, 0, 0);
    check_idle("rstmid.redo", 16'd15);

    // Randomized operands with varied multiplier bit lengths.
    for (int i = 0; i < 24; i++) begin
      ra   = 16'($urandom);
      mask = (32'd1 << $urandom_range(0, 16)) - 32'd1;
      rb   = 16'($urandom & mask);
      @(negedge clk); start = 1'b1; a = ra; b = rb;
      wait_done($sformatf("rnd%0d", i), rb, ref_prod(ra, rb), 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
